fetch_stage: RTL

Instruction-fetch stage of the MIPS datapath, directly upstream of the instruction memory. It holds the program counter and drives the 8-bit word address into the combinational instruction memory. It captures the returned 32-bit word into an IF/ID pipeline register for the decode stage. It also applies stall, branch and jump redirects resolved in decode, squashes the wrong-path fetch, and counts delivered instructions.

---
 rtl/fetch_stage.sv | 89 ++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register and
// delivered-instruction counter, with decode-resolved branch/jump redirects.
module fetch_stage #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [15:0]            branch_offset,
  input  logic                   jump,
  input  logic [25:0]            jump_index,
  output logic [PC_WIDTH-1:0]    pc,
  input  logic [INSTR_WIDTH-1:0] instruction_in,
  output logic [INSTR_WIDTH-1:0] ifid_instruction,
  output logic [PC_WIDTH-1:0]    ifid_pc_plus1,
  output logic                   ifid_valid,
  output logic [15:0]            fetch_count
);

  // ifid_valid qualifies the IF/ID contents: when low the register holds a
  // nop bubble, and decode-side redirect requests are ignored because a bubble
  // cannot be a branch or jump.
  logic                   jump_en;
  logic                   branch_en;
  logic                   load_valid;
  logic [PC_WIDTH-1:0]    pc_plus1;
  logic [PC_WIDTH-1:0]    branch_target;
  logic [PC_WIDTH-1:0]    next_pc;
  logic [INSTR_WIDTH-1:0] next_instruction;
  logic [PC_WIDTH-1:0]    next_pc_plus1;
  logic                   next_valid;
  logic [15:0]            next_count;

  assign jump_en       = ifid_valid & jump;
  assign branch_en     = ifid_valid & branch_taken;
  assign pc_plus1      = pc + PC_WIDTH'(1);
  assign branch_target = ifid_pc_plus1 + branch_offset[PC_WIDTH-1:0];

  // Priority: jump, then branch (both squash), then stall, then sequential.
  always_comb begin
    next_pc          = pc;
    next_instruction = ifid_instruction;
    next_pc_plus1    = ifid_pc_plus1;
    next_valid       = ifid_valid;
    load_valid       = 1'b0;
    if (jump_en) begin
      next_pc          = jump_index[PC_WIDTH-1:0];
      next_instruction = '0;
      next_valid       = 1'b0;
    end else if (branch_en) begin
      next_pc          = branch_target;
      next_instruction = '0;
      next_valid       = 1'b0;
    end else if (!stall) begin
      next_pc          = pc_plus1;
      next_instruction = instruction_in;
      next_pc_plus1    = pc_plus1;
      next_valid       = 1'b1;
      load_valid       = 1'b1;
    end
  end

  always_comb begin
    next_count = fetch_count;
    if (load_valid && fetch_count != 16'hFFFF) begin
      next_count = fetch_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc               <= RESET_PC;
      ifid_instruction <= '0;
      ifid_pc_plus1    <= '0;
      ifid_valid       <= 1'b0;
      fetch_count      <= '0;
    end else begin
      pc               <= next_pc;
      ifid_instruction <= next_instruction;
      ifid_pc_plus1    <= next_pc_plus1;
      ifid_valid       <= next_valid;
      fetch_count      <= next_count;
    end
  end

endmodule
